i2c_master: RTL and testbench
=============================

Name: i2c_master

Overview:
- Byte-level I2C bus master controller.
- A host issues one command at a time (START, WRITE, READ, STOP, RESTART) through a simple strobe interface.
- The block generates open-drain SCL/SDA waveforms at a programmable rate, shifts bytes out and in, and returns the ACK bit and the read byte.
- It sits between a CPU/register wrapper and the physical I2C pins, which have external or bench pull-ups.

Parameters:
- None. The bus rate is set at runtime by dvsr_i.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous, active-high reset
- din_i  input  8  write byte; for READ, din_i[0] is the ACK bit master drives (0=ACK, 1=NACK)
- dvsr_i  input  16  quarter SCL period in clk_i cycles (dvsr = f_clk/(4*f_scl)); must be >=1
- cmd_i  input  3  000 START, 001 WR, 010 RD, 011 STOP, 100 RESTART; others ignored
- wr_i2c_i  input  1  command strobe, sampled only while ready_o=1
- scl_io  inout  1  open-drain clock: drives 0 or Z, never 1
- sda_io  inout  1  open-drain data: drives 0 or Z, never 1
- ready_o  output  1  high when a new command can be accepted
- done_tick_o  output  1  one-cycle pulse at end of each WR/RD byte
- ack_o  output  1  9th bit sampled on SDA (slave ACK after WR; master's own bit after RD)
- dout_o  output  8  byte sampled on SDA, MSB first

Behaviour:
- Timing unit: Q = dvsr_i clock cycles; H = 2*Q.
- A 16-bit counter clears on every state entry. The state exits when the counter reaches its limit minus 1.
- dvsr_i is held stable by the host during a transaction.
- Line levels: "1" means released (Z), "0" means driven low.

Reset (synchronous, rst_i=1):
- state=IDLE, SCL=1, SDA=1 (both released), counter=0, bit count=0, shift registers=0.
- ready_o=1, done_tick_o=0, ack_o=0, dout_o=0.

States:
- IDLE: SCL=1, SDA=1, ready=1.
  - wr_i2c_i with START -> START1.
  - All other commands ignored.
- START1: SCL=1, SDA=0 for H -> START2.
- START2: SCL=0, SDA=0 for Q -> HOLD.
- HOLD: SCL=0, SDA=0, ready=1. On wr_i2c_i:
  - WR/RD: load 9-bit TX = {din_i,1} for WR or {8'hFF,din_i[0]} for RD; bit count=0; -> DATA1.
  - START or RESTART -> RESTART.
  - STOP -> STOP1.
- DATA1: SCL=0, SDA=TX[8] for Q -> DATA2.
- DATA2: SCL=1, SDA=TX[8] for Q. On exit, shift the sampled SDA into RX LSB -> DATA3.
- DATA3: SCL=1, SDA=TX[8] for Q -> DATA4.
- DATA4: SCL=0, SDA=TX[8] for Q. On exit:
  - If bit count=8 -> DATA_END.
  - Else shift TX left, increment bit count -> DATA1.
- DATA_END: SCL=0, SDA=0 for Q. On exit: done_tick_o=1 for one cycle -> HOLD.
- RESTART: SCL=1, SDA=1 for H -> START1.
- STOP1: SCL=1, SDA=0 for H -> STOP2.
- STOP2: SCL=1, SDA=1 for H -> IDLE.

Outputs and rules:
- dout_o = RX[8:1]; ack_o = RX[0]. Both update after each byte and hold until the next byte.
- SDA changes only while SCL=0 during data phases; START/STOP transitions occur while SCL=1.
- wr_i2c_i while ready_o=0 is ignored; there is no queueing.
- SDA/SCL are registered, so the pins are glitch-free.
- Reset asserted in any state aborts the operation immediately: next cycle is IDLE with both lines released.
- No clock stretching and no arbitration-loss detection.

Test Plan:
- Reset: hold rst_i 3 cycles -> scl_io=sda_io=1 (pulled), ready_o=1, done_tick_o=0, dout_o=0.
- START then STOP, dvsr=4: SDA falls while SCL high, then 8 cycles later SCL falls 4 cycles after that, ready_o=1 in HOLD. STOP -> SDA rises while SCL high; IDLE after 16 cycles.
- WR 8'hA5 with slave model pulling SDA low on the 9th clock -> SDA bits 1,0,1,0,0,1,0,1 valid on each SCL high; 9 SCL pulses of 8 cycles each; done_tick_o single pulse; ack_o=0.
- WR with no slave (SDA left pulled up) -> ack_o=1 (NACK); state returns to HOLD, ready_o=1.
- RD, din_i[0]=1, slave drives 8'h3C -> dout_o=8'h3C; master releases SDA on the 9th bit; ack_o=1.
- RESTART from HOLD, plus a strobe during a byte plus reset mid-byte:
  - RESTART -> SDA rises, SCL rises, then a new START condition.
  - wr_i2c_i while busy -> no effect.
  - rst_i mid-byte -> IDLE next cycle, lines released.

Source files
------------

// File: rtl/i2c_master.sv
// i2c_master: byte-level I2C bus master; open-drain SCL/SDA at a rate set by dvsr_i.
module i2c_master (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  din_i,
  input  logic [15:0] dvsr_i,
  input  logic [2:0]  cmd_i,
  input  logic        wr_i2c_i,
  inout  wire         scl_io,
  inout  wire         sda_io,
  output logic        ready_o,
  output logic        done_tick_o,
  output logic        ack_o,
  output logic [7:0]  dout_o
);
  localparam logic [2:0] CMD_START = 3'b000, CMD_WR = 3'b001, CMD_RD = 3'b010,
                         CMD_STOP = 3'b011, CMD_RESTART = 3'b100;
  typedef enum logic [3:0] {
    IDLE, START1, START2, HOLD, DATA1, DATA2, DATA3, DATA4, DATA_END, RESTART, STOP1, STOP2
  } state_t;
  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [3:0]  bit_cnt, bit_n;
  logic [8:0]  tx, tx_n, rx, rx_n;
  logic        scl_q, sda_q, scl_n, sda_n, done_n, q_end, h_end;
  logic [7:0]  dout_q;
  logic        ack_q, done_q;
  always_comb begin
    q_end   = cnt == dvsr_i - 16'd1;
    h_end   = cnt == {dvsr_i[14:0], 1'b0} - 16'd1;
    state_n = state;
    tx_n    = tx;
    rx_n    = rx;
    bit_n   = bit_cnt;
    done_n  = 1'b0;
    case (state)
      IDLE:     if (wr_i2c_i && cmd_i == CMD_START) state_n = START1;
      START1:   if (h_end) state_n = START2;
      START2:   if (q_end) state_n = HOLD;
      HOLD: begin
        if (wr_i2c_i) begin
          if (cmd_i == CMD_WR || cmd_i == CMD_RD) begin
            tx_n    = cmd_i == CMD_WR ? {din_i, 1'b1} : {8'hff, din_i[0]};
            bit_n   = 4'd0;
            state_n = DATA1;
          end else if (cmd_i == CMD_START || cmd_i == CMD_RESTART) state_n = RESTART;
          else if (cmd_i == CMD_STOP) state_n = STOP1;
        end
      end
      DATA1:    if (q_end) state_n = DATA2;
      DATA2: begin
        if (q_end) begin
          rx_n    = {rx[7:0], sda_io};
          state_n = DATA3;
        end
      end
      DATA3:    if (q_end) state_n = DATA4;
      DATA4: begin
        if (q_end) begin
          if (bit_cnt == 4'd8) state_n = DATA_END;
          else begin
            tx_n    = {tx[7:0], 1'b0};
            bit_n   = bit_cnt + 4'd1;
            state_n = DATA1;
          end
        end
      end
      DATA_END: begin
        if (q_end) begin
          done_n  = 1'b1;
          state_n = HOLD;
        end
      end
      RESTART:  if (h_end) state_n = START1;
      STOP1:    if (h_end) state_n = STOP2;
      STOP2:    if (h_end) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    cnt_n = state_n == state ? cnt + 16'd1 : 16'd0;
    // line levels follow the state being entered so pins and state change together
    scl_n = !(state_n inside {START2, HOLD, DATA1, DATA4, DATA_END});
    sda_n = state_n inside {IDLE, RESTART, STOP2} ? 1'b1 :
            state_n inside {DATA1, DATA2, DATA3, DATA4} ? tx_n[8] : 1'b0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      tx      <= '0;
      rx      <= '0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      done_q  <= 1'b0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      tx      <= tx_n;
      rx      <= rx_n;
      scl_q   <= scl_n;
      sda_q   <= sda_n;
      done_q  <= done_n;
      if (done_n) begin
        dout_q <= rx[8:1];
        ack_q  <= rx[0];
      end
    end
  end
  assign scl_io      = scl_q ? 1'bz : 1'b0;
  assign sda_io      = sda_q ? 1'bz : 1'b0;
  assign ready_o     = state == IDLE || state == HOLD;
  assign done_tick_o = done_q;
  assign dout_o      = dout_q;
  assign ack_o       = ack_q;
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed bench for i2c_master with a cycle-scheduled slave on SDA.
module tb_i2c_master;
  logic        clk = 1'b0, rst = 1'b0, wr = 1'b0, slave_low = 1'b0;
  logic [7:0]  din = '0;
  logic [15:0] dvsr = 16'd4;
  logic [2:0]  cmd = '0;
  logic        ready, done_tick, ack;
  logic [7:0]  dout;
  wire         scl, sda;
  int          n_cmp = 0, n_err = 0;
  pullup (scl);
  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;
  i2c_master dut (
    .clk_i(clk), .rst_i(rst), .din_i(din), .dvsr_i(dvsr), .cmd_i(cmd), .wr_i2c_i(wr),
    .scl_io(scl), .sda_io(sda), .ready_o(ready), .done_tick_o(done_tick), .ack_o(ack), .dout_o(dout)
  );
  always #5 clk = ~clk;
  logic       scl_d = 1'b1;
  logic [8:0] sda_bits = '0;
  int         pulses = 0, dones = 0;
  // records SDA at every SCL rise and counts done pulses
  always @(negedge clk) begin
    scl_d <= scl;
    if (scl && !scl_d) begin
      pulses   <= pulses + 1;
      sda_bits <= {sda_bits[7:0], sda};
    end
    if (done_tick) dones <= dones + 1;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [2:0] c, input logic [7:0] d);
    cmd = c;
    din = d;
    wr  = 1'b1;
    tick(1);
    wr  = 1'b0;
  endtask
  // one byte; sl is the 9-bit pattern the slave leaves released (1) or pulls low (0)
  task automatic xfer(input string tag, input logic [2:0] c, input logic [7:0] d,
                      input logic [8:0] sl, input logic [8:0] exp_bits, input logic poke);
    int p0, d0;
    p0 = pulses;
    d0 = dones;
    issue(c, d);
    for (int k = 0; k < 9; k++) begin
      slave_low = ~sl[8-k];
      if (poke && k == 3) begin
        chk({tag, "_busy"}, {15'd0, ready}, 16'd0);
        issue(3'b011, 8'h00);
        tick(15);
      end else tick(16);
    end
    slave_low = 1'b0;
    tick(3);
    chk({tag, "_notyet"}, {15'd0, ready}, 16'd0);
    tick(1);
    chk({tag, "_ready"}, {15'd0, ready}, 16'd1);
    chk({tag, "_done"}, {15'd0, done_tick}, 16'd1);
    tick(2);
    chk({tag, "_done_off"}, {15'd0, done_tick}, 16'd0);
    chk({tag, "_ndone"}, 16'(dones - d0), 16'd1);
    chk({tag, "_pulses"}, 16'(pulses - p0), 16'd9);
    chk({tag, "_bits"}, {7'd0, sda_bits}, {7'd0, exp_bits});
    chk({tag, "_dout"}, {8'd0, dout}, {8'd0, exp_bits[8:1]});
    chk({tag, "_ack"}, {15'd0, ack}, {15'd0, exp_bits[0]});
    chk({tag, "_hold_scl"}, {15'd0, scl}, 16'd0);
  endtask
  initial begin
    rst = 1'b1;
    tick(3);
    chk("rst_scl", {15'd0, scl}, 16'd1);
    chk("rst_sda", {15'd0, sda}, 16'd1);
    chk("rst_ready", {15'd0, ready}, 16'd1);
    chk("rst_done", {15'd0, done_tick}, 16'd0);
    chk("rst_dout", {8'd0, dout}, 16'd0);
    chk("rst_ack", {15'd0, ack}, 16'd0);
    rst = 1'b0;
    tick(1);
    issue(3'b001, 8'h55);
    tick(3);
    chk("idle_ign_ready", {15'd0, ready}, 16'd1);
    chk("idle_ign_sda", {15'd0, sda}, 16'd1);
    chk("idle_ign_scl", {15'd0, scl}, 16'd1);
    issue(3'b000, 8'h00);
    chk("start_sda", {15'd0, sda}, 16'd0);
    chk("start_scl", {15'd0, scl}, 16'd1);
    chk("start_busy", {15'd0, ready}, 16'd0);
    tick(7);
    chk("start1_scl", {15'd0, scl}, 16'd1);
    tick(1);
    chk("start2_scl", {15'd0, scl}, 16'd0);
    chk("start2_sda", {15'd0, sda}, 16'd0);
    tick(3);
    chk("start2_busy", {15'd0, ready}, 16'd0);
    tick(1);
    chk("hold_ready", {15'd0, ready}, 16'd1);
    issue(3'b011, 8'h00);
    chk("stop1_scl", {15'd0, scl}, 16'd1);
    chk("stop1_sda", {15'd0, sda}, 16'd0);
    tick(7);
    chk("stop1_end_sda", {15'd0, sda}, 16'd0);
    tick(1);
    chk("stop2_sda", {15'd0, sda}, 16'd1);
    chk("stop2_scl", {15'd0, scl}, 16'd1);
    tick(7);
    chk("stop2_busy", {15'd0, ready}, 16'd0);
    tick(1);
    chk("idle_ready", {15'd0, ready}, 16'd1);
    issue(3'b000, 8'h00);
    tick(12);
    chk("hold2_ready", {15'd0, ready}, 16'd1);
    xfer("wr_a5", 3'b001, 8'hA5, 9'h1FE, {8'hA5, 1'b0}, 1'b1);
    xfer("wr_nack", 3'b001, 8'h5A, 9'h1FF, {8'h5A, 1'b1}, 1'b0);
    xfer("rd_3c", 3'b010, 8'h01, {8'h3C, 1'b1}, {8'h3C, 1'b1}, 1'b0);
    issue(3'b100, 8'h00);
    chk("rs_scl", {15'd0, scl}, 16'd1);
    chk("rs_sda", {15'd0, sda}, 16'd1);
    tick(7);
    chk("rs_end_sda", {15'd0, sda}, 16'd1);
    tick(1);
    chk("rs_start_sda", {15'd0, sda}, 16'd0);
    chk("rs_start_scl", {15'd0, scl}, 16'd1);
    tick(8);
    chk("rs_start2_scl", {15'd0, scl}, 16'd0);
    tick(4);
    chk("rs_hold_ready", {15'd0, ready}, 16'd1);
    issue(3'b001, 8'h81);
    tick(40);
    chk("mid_busy", {15'd0, ready}, 16'd0);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_ready", {15'd0, ready}, 16'd1);
    chk("mid_rst_scl", {15'd0, scl}, 16'd1);
    chk("mid_rst_sda", {15'd0, sda}, 16'd1);
    chk("mid_rst_dout", {8'd0, dout}, 16'd0);
    chk("mid_rst_ack", {15'd0, ack}, 16'd0);
    rst = 1'b0;
    tick(5);
    chk("post_rst_scl", {15'd0, scl}, 16'd1);
    chk("post_rst_done", 16'(dones), 16'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
